// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: multiplexed common-anode seven-segment scanner.
// Scans DIGITS digits, decodes hex nibbles with per-digit decimal point,
// blanking, leading-zero suppression and PWM brightness. A pending/shadow
// register pair double-buffers the displayed value; updates are applied only
// at the frame boundary, so a frame never shows a mix of old and new data.
// Optional feature macro: SSD_BLINK_EN (adds i_blink_mask and BLINK_FRAMES).
//
// Load handshake: i_load is a single-cycle strobe with no back-pressure; every
// strobe is accepted. o_load_ack pulses once for each update that reaches the
// display, one cycle after the o_frame pulse of the frame that first shows it.
module ssd_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int DIGIT_CYCLES = 16384,
    parameter int DUTY_W       = 3
`ifdef SSD_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 32
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [4*DIGITS-1:0]   i_val,
    input  logic [DIGITS-1:0]     i_dp_in,
    input  logic [DIGITS-1:0]     i_blank,
    input  logic                  i_lz_en,
    input  logic [DUTY_W-1:0]     i_bright,
    input  logic                  i_load,
`ifdef SSD_BLINK_EN
    input  logic [DIGITS-1:0]     i_blink_mask,
`endif
    output logic                  o_load_ack,
    output logic                  o_frame,
    output logic [DIGITS-1:0]     o_an,
    output logic [6:0]            o_seg,
    output logic                  o_dp
);

    localparam int PW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIGIT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    // Scan position
    logic [PW-1:0]       r_presc;
    logic [IW-1:0]       r_idx;

    // Pending (written by load) and shadow (on display) buffers
    logic [4*DIGITS-1:0] r_pend_val;
    logic [DIGITS-1:0]   r_pend_dp;
    logic [DIGITS-1:0]   r_pend_blank;
    logic                r_pend_lz;
    logic                r_pend_flag;
    logic [4*DIGITS-1:0] r_sh_val;
    logic [DIGITS-1:0]   r_sh_dp;
    logic [DIGITS-1:0]   r_sh_blank;
    logic                r_sh_lz;
    logic                r_applied;
    logic                r_ack;
    logic                r_frame;

    logic                w_presc_tc;
    logic                w_boundary;
    logic [DIGITS-1:0]   w_lz_sup;
    logic [3:0]          w_nib;
    logic [6:0]          w_seg_dec;
    logic                w_pwm_on;
    logic                w_blink_dark;
    logic                w_digit_on;
    logic [DIGITS-1:0]   w_an_sel;

    assign w_presc_tc = (r_presc == PRESC_LAST);
    // Last cycle of the last digit slot; the next cycle is the frame start
    assign w_boundary = w_presc_tc && (r_idx == IDX_LAST);

    // Prescaler and digit index
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_presc_tc) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Pending/shadow double buffer; a load coinciding with the last cycle
    // before the frame start is forwarded straight into the shadow so that it
    // still makes the upcoming frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '1;
            r_pend_lz    <= 1'b0;
            r_pend_flag  <= 1'b0;
            r_sh_val     <= '0;
            r_sh_dp      <= '0;
            r_sh_blank   <= '1;
            r_sh_lz      <= 1'b0;
            r_applied    <= 1'b0;
        end else begin
            r_applied <= 1'b0;
            if (w_boundary && i_load) begin
                r_sh_val    <= i_val;
                r_sh_dp     <= i_dp_in;
                r_sh_blank  <= i_blank;
                r_sh_lz     <= i_lz_en;
                r_pend_flag <= 1'b0;
                r_applied   <= 1'b1;
            end else if (w_boundary && r_pend_flag) begin
                r_sh_val    <= r_pend_val;
                r_sh_dp     <= r_pend_dp;
                r_sh_blank  <= r_pend_blank;
                r_sh_lz     <= r_pend_lz;
                r_pend_flag <= 1'b0;
                r_applied   <= 1'b1;
            end else if (i_load) begin
                r_pend_val   <= i_val;
                r_pend_dp    <= i_dp_in;
                r_pend_blank <= i_blank;
                r_pend_lz    <= i_lz_en;
                r_pend_flag  <= 1'b1;
            end
        end
    end

    // Frame pulse and load acknowledge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_frame <= w_boundary;
            r_ack   <= r_applied;
        end
    end

`ifdef SSD_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_FRAMES - 1);
    logic [FW-1:0] r_blink_cnt;
    logic          r_blink_phase;

    // Blink phase toggles every BLINK_FRAMES frames
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_boundary) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_blink_dark = r_blink_phase & i_blink_mask[r_idx];
`else
    assign w_blink_dark = 1'b0;
`endif

    // Leading zeros: suppress from the top digit down until a non-zero nibble
    always_comb begin
        logic v_leading;
        w_lz_sup  = '0;
        v_leading = r_sh_lz;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (v_leading && (r_sh_val[4*i +: 4] == 4'h0)) begin
                w_lz_sup[i] = 1'b1;
            end else begin
                v_leading = 1'b0;
            end
        end
    end

    assign w_nib = r_sh_val[{r_idx, 2'b00} +: 4];

    // Hex to active-low segments {g,f,e,d,c,b,a}
    always_comb begin
        w_seg_dec = 7'h7F;
        case (w_nib)
            4'h0: w_seg_dec = 7'h40;
            4'h1: w_seg_dec = 7'h79;
            4'h2: w_seg_dec = 7'h24;
            4'h3: w_seg_dec = 7'h30;
            4'h4: w_seg_dec = 7'h19;
            4'h5: w_seg_dec = 7'h12;
            4'h6: w_seg_dec = 7'h02;
            4'h7: w_seg_dec = 7'h78;
            4'h8: w_seg_dec = 7'h00;
            4'h9: w_seg_dec = 7'h10;
            4'hA: w_seg_dec = 7'h08;
            4'hB: w_seg_dec = 7'h03;
            4'hC: w_seg_dec = 7'h46;
            4'hD: w_seg_dec = 7'h21;
            4'hE: w_seg_dec = 7'h06;
            4'hF: w_seg_dec = 7'h0E;
            default: w_seg_dec = 7'h7F;
        endcase
    end

    // One-hot select of the active digit
    always_comb begin
        w_an_sel        = '0;
        w_an_sel[r_idx] = 1'b1;
    end

    assign w_pwm_on   = (r_presc[DUTY_W-1:0] <= i_bright);
    assign w_digit_on = ~r_sh_blank[r_idx] & ~w_lz_sup[r_idx] & w_pwm_on & ~w_blink_dark;

    // Registered pin drivers; a dark digit drives every pin inactive
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_an  <= '1;
            o_seg <= 7'h7F;
            o_dp  <= 1'b1;
        end else if (w_digit_on) begin
            o_an  <= ~w_an_sel;
            o_seg <= w_seg_dec;
            o_dp  <= ~r_sh_dp[r_idx];
        end else begin
            o_an  <= '1;
            o_seg <= 7'h7F;
            o_dp  <= 1'b1;
        end
    end

    assign o_load_ack = r_ack;
    assign o_frame    = r_frame;

endmodule
